// File: rtl/nvme_pcheck_mlane.sv
// ---------------------------------------------------------------------------
// nvme_pcheck_mlane
//
// Registered multi-lane byte-group parity checker with error capture.
// Each of `channels` lanes carries `width` data bits protected by `pwidth`
// group-parity bits. The checker is a two-stage pipeline:
//   stage 1 registers the inputs, stage 2 computes and registers the lane
//   errors. Status (sticky bits, first-error capture, saturating event
//   counter) updates on the edge after an error pulse is visible.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   data, datap       lane c at [c*width +: width] / [c*pwidth +: pwidth]
//   oddpar            1 = odd parity, 0 = even, shared by all lanes
//   check             per-lane qualifier; unqualified lanes never flag
//   clear             synchronous clear of sticky / capture / counter
//   parerr            per-lane registered error pulse
//   parerr_any        registered OR of parerr
//   sticky            accumulated per-lane error status
//   first_vld         first_ch holds a captured lane
//   first_ch          lowest erroring lane of the first error event
//   errcnt            saturating count of cycles with parerr_any=1
//
// Optional feature (macro NVME_PCHECK_INJECT_EN):
//   inj_req, inj_ch   arm a one-shot error on lane inj_ch
//   inj_ack           pulses together with the forced parerr
// Without the macro the checker is purely observational.
// ---------------------------------------------------------------------------
module nvme_pcheck_mlane #(
    parameter int bits_per_parity_bit = 8,
    parameter int width               = 128,
    parameter int channels            = 4,
    parameter int cntwidth            = 16,
    localparam int pwidth  = (width + bits_per_parity_bit - 1) / bits_per_parity_bit,
    localparam int chwidth = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [channels*width-1:0]    data,
    input  logic [channels*pwidth-1:0]   datap,
    input  logic                         oddpar,
    input  logic [channels-1:0]          check,
    input  logic                         clear,
    output logic [channels-1:0]          parerr,
    output logic                         parerr_any,
    output logic [channels-1:0]          sticky,
    output logic                         first_vld,
    output logic [chwidth-1:0]           first_ch,
    output logic [cntwidth-1:0]          errcnt
`ifdef NVME_PCHECK_INJECT_EN
    ,
    input  logic                         inj_req,
    input  logic [chwidth-1:0]           inj_ch,
    output logic                         inj_ack
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CAPT = 1'b1} state_t;

    // Calculated group parity; the last group may be partial, bits beyond
    // width simply do not exist and so do not contribute.
    function automatic logic [pwidth-1:0] f_calc(input logic [width-1:0] d,
                                                 input logic odd);
        logic [pwidth-1:0] p;
        p = {pwidth{odd}};
        for (int b = 0; b < width; b++) begin
            p[b / bits_per_parity_bit] = p[b / bits_per_parity_bit] ^ d[b];
        end
        return p;
    endfunction

    function automatic logic [chwidth-1:0] f_lowest(input logic [channels-1:0] v);
        logic [chwidth-1:0] idx;
        idx = '0;
        for (int c = channels - 1; c >= 0; c--) begin
            if (v[c]) idx = chwidth'(c);
        end
        return idx;
    endfunction

    logic [channels*width-1:0]  r_data_p1;
    logic [channels*pwidth-1:0] r_datap_p1;
    logic                       r_oddpar_p1;
    logic [channels-1:0]        r_check_p1;

    logic [channels-1:0]        r_parerr_p2;
    logic                       r_parerr_any_p2;

    logic [channels-1:0]        r_sticky;
    logic [cntwidth-1:0]        r_errcnt;
    logic [chwidth-1:0]         r_first_ch;
    state_t                     r_state;

    logic [channels-1:0]        w_err;
    logic [chwidth-1:0]         w_first_ch_nxt;
    state_t                     w_state_nxt;

`ifdef NVME_PCHECK_INJECT_EN
    logic                       r_inj_pend;
    logic [chwidth-1:0]         r_inj_ch;
    logic                       r_inj_ack;
    logic                       w_inj_hit;

    // The armed lane is consumed by the first stage-1 cycle that qualifies it.
    assign w_inj_hit = r_inj_pend & r_check_p1[r_inj_ch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inj_pend <= 1'b0;
            r_inj_ch   <= '0;
            r_inj_ack  <= 1'b0;
        end else begin
            r_inj_ack <= w_inj_hit;
            if (w_inj_hit) begin
                r_inj_pend <= 1'b0;
            end else if (!r_inj_pend && inj_req &&
                         ({1'b0, inj_ch} < (chwidth + 1)'(channels))) begin
                r_inj_pend <= 1'b1;
                r_inj_ch   <= inj_ch;
            end
        end
    end

    assign inj_ack = r_inj_ack;
`endif

    // ---- stage 1: input registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_p1   <= '0;
            r_datap_p1  <= '0;
            r_oddpar_p1 <= 1'b0;
            r_check_p1  <= '0;
        end else begin
            r_data_p1   <= data;
            r_datap_p1  <= datap;
            r_oddpar_p1 <= oddpar;
            r_check_p1  <= check;
        end
    end

    // ---- stage 2: lane error evaluation ----
    always_comb begin
        logic [pwidth-1:0] v_calc;
        w_err = '0;
        for (int c = 0; c < channels; c++) begin
            v_calc = f_calc(r_data_p1[c*width +: width], r_oddpar_p1);
`ifdef NVME_PCHECK_INJECT_EN
            if (r_inj_pend && (r_inj_ch == chwidth'(c))) v_calc[0] = ~v_calc[0];
`endif
            w_err[c] = r_check_p1[c] & (|(v_calc ^ r_datap_p1[c*pwidth +: pwidth]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parerr_p2     <= '0;
            r_parerr_any_p2 <= 1'b0;
        end else begin
            r_parerr_p2     <= w_err;
            r_parerr_any_p2 <= |w_err;
        end
    end

    // ---- status: sticky bits and saturating counter ----
    // clear discards history but still records the error visible this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= '0;
            r_errcnt <= '0;
        end else if (clear) begin
            r_sticky <= r_parerr_p2;
            r_errcnt <= cntwidth'(r_parerr_any_p2);
        end else begin
            r_sticky <= r_sticky | r_parerr_p2;
            if (r_parerr_any_p2 && (r_errcnt != '1)) r_errcnt <= r_errcnt + 1'b1;
        end
    end

    // ---- capture FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_first_ch <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_first_ch <= w_first_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_first_ch_nxt = r_first_ch;
        if (clear) begin
            if (r_parerr_any_p2) begin
                w_state_nxt    = ST_CAPT;
                w_first_ch_nxt = f_lowest(r_parerr_p2);
            end else begin
                w_state_nxt    = ST_IDLE;
                w_first_ch_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_parerr_any_p2) begin
                        w_state_nxt    = ST_CAPT;
                        w_first_ch_nxt = f_lowest(r_parerr_p2);
                    end
                end
                ST_CAPT: begin
                    w_state_nxt = ST_CAPT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign parerr     = r_parerr_p2;
    assign parerr_any = r_parerr_any_p2;
    assign sticky     = r_sticky;
    assign errcnt     = r_errcnt;
    assign first_ch   = r_first_ch;
    assign first_vld  = (r_state == ST_CAPT);

endmodule
